// File: rtl/conv_window_buffer.sv
// Sliding KxK window generator over a raster pixel stream.
// Line buffers feed the right column; windows emitted at valid positions only.
module conv_window_buffer #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 5,
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  input  logic pixel_valid,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] pixel_data,
  output logic window_valid,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
  output logic [$clog2(IMG_WIDTH)-1:0] win_col,
  output logic frame_done
);

  localparam int K      = KERNEL_SIZE;
  localparam int NPIX   = K * K;
  localparam int LB_LEN = (K - 1) * IMG_WIDTH;
  localparam int RW     = $clog2(IMG_HEIGHT);
  localparam int CW     = $clog2(IMG_WIDTH);

  logic [DATA_WIDTH-1:0] lb  [LB_LEN];
  logic [DATA_WIDTH-1:0] win [NPIX];
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic in_win;
  logic last_pix;
  logic row_end;
  logic take;

  assign row_end  = (col == CW'(IMG_WIDTH - 1));
  assign last_pix = row_end && (row == RW'(IMG_HEIGHT - 1));
  assign in_win   = (row >= RW'(K - 1)) && (col >= CW'(K - 1));
  assign take     = pixel_valid && !restart;

  for (genvar g = 0; g < NPIX; g++) begin : g_flat
    assign pixel_data[g*DATA_WIDTH +: DATA_WIDTH] = win[g];
  end

  // Line buffers: one long shift chain, lb[j] is the pixel j+1 accepts ago
  always_ff @(posedge clk) begin
    if (pixel_valid) begin
      lb[0] <= pixel_in;
      for (int j = 1; j < LB_LEN; j++) begin
        lb[j] <= lb[j-1];
      end
    end
  end

  // Window: shift left, right column loads from line-buffer taps
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NPIX; i++) begin
        win[i] <= '0;
      end
    end else if (pixel_valid) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win[r*K+c] <= win[r*K+c+1];
        end
        if (r == K - 1) begin
          win[r*K+K-1] <= pixel_in;
        end else begin
          win[r*K+K-1] <= lb[(K-1-r)*IMG_WIDTH-1];
        end
      end
    end
  end

  // Position of the next pixel to be accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row <= '0;
      col <= '0;
    end else if (restart) begin
      row <= '0;
      col <= pixel_valid ? CW'(1) : '0;
    end else if (pixel_valid) begin
      if (row_end) begin
        col <= '0;
        row <= last_pix ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Window strobe, output-map coordinates and end-of-frame pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      win_row      <= '0;
      win_col      <= '0;
    end else begin
      window_valid <= take && in_win;
      frame_done   <= take && last_pix;
      if (take && in_win) begin
        win_row <= row - RW'(K - 1);
        win_col <= col - CW'(K - 1);
      end
    end
  end

endmodule

// File: tb/tb_conv_window_buffer.sv
// Directed bench for conv_window_buffer (K=5, 28x28).
// Frame-image model predicts every window and strobe.
module tb_conv_window_buffer;

  logic clk = 0;
  logic rst_n = 0;
  logic restart = 0;
  logic [15:0] pixel_in = '0;
  logic pixel_valid = 0;
  logic [399:0] pixel_data;
  logic window_valid;
  logic [4:0] win_row;
  logic [4:0] win_col;
  logic frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] img [28][28];
  int mrow = 0;
  int mcol = 0;
  int acc = 0;
  int first = -1;
  int win_cnt = 0;
  int fd_cnt = 0;

  conv_window_buffer dut (
    .clk(clk),
    .reset(rst_n),
    .restart(restart),
    .pixel_in(pixel_in),
    .pixel_valid(pixel_valid),
    .pixel_data(pixel_data),
    .window_valid(window_valid),
    .win_row(win_row),
    .win_col(win_col),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [399:0] got,
                       input logic [399:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_stats();
    acc = 0;
    first = -1;
    win_cnt = 0;
    fd_cnt = 0;
  endtask

  task automatic push(input logic [15:0] pix,
                      input logic v,
                      input logic rs);
    int pr;
    int pc;
    logic ewv;
    logic efd;
    logic [399:0] ew;
    @(negedge clk);
    pixel_in = pix;
    pixel_valid = v;
    restart = rs;
    @(posedge clk);
    #1;
    pixel_valid = 0;
    restart = 0;
    ewv = 0;
    efd = 0;
    pr = 0;
    pc = 0;
    if (rs) begin
      mrow = 0;
      mcol = 0;
      if (v) begin
        img[0][0] = pix;
        mcol = 1;
        acc++;
      end
    end else if (v) begin
      pr = mrow;
      pc = mcol;
      img[pr][pc] = pix;
      ewv = (pr >= 4) && (pc >= 4);
      efd = (pr == 27) && (pc == 27);
      acc++;
      if (mcol == 27) begin
        mcol = 0;
        mrow = (mrow == 27) ? 0 : mrow + 1;
      end else begin
        mcol++;
      end
    end
    check("window_valid", {399'b0, window_valid}, {399'b0, ewv});
    check("frame_done", {399'b0, frame_done}, {399'b0, efd});
    if (ewv) begin
      ew = '0;
      for (int rr = 0; rr < 5; rr++) begin
        for (int cc = 0; cc < 5; cc++) begin
          ew[(rr*5+cc)*16 +: 16] = img[pr-4+rr][pc-4+cc];
        end
      end
      check("win_row", {395'b0, win_row}, 400'(pr - 4));
      check("win_col", {395'b0, win_col}, 400'(pc - 4));
      check("pixel_data", pixel_data, ew);
    end
    if (window_valid) begin
      win_cnt++;
      if (first < 0) first = acc - 1;
    end
    if (frame_done) fd_cnt++;
  endtask

  function automatic logic [15:0] el(input int i);
    return pixel_data[i*16 +: 16];
  endfunction

  initial begin
    int p;
    int s;
    logic [31:0] sum;
    for (int r = 0; r < 28; r++) begin
      for (int c = 0; c < 28; c++) begin
        img[r][c] = '0;
      end
    end

    // reset state
    #23;
    check("rst_wv", {399'b0, window_valid}, '0);
    check("rst_data", pixel_data, '0);
    @(negedge clk);
    rst_n = 1;

    // stream part of a frame, then async reset between edges
    for (int i = 0; i < 205; i++) push(16'(i), 1'b1, 1'b0);
    check("pre_rst_wv", {399'b0, window_valid}, 400'd1);
    #3;
    rst_n = 0;
    #1;
    check("arst_data", pixel_data, '0);
    check("arst_wv", {399'b0, window_valid}, '0);
    check("arst_row", {395'b0, win_row}, '0);
    check("arst_col", {395'b0, win_col}, '0);
    check("arst_fd", {399'b0, frame_done}, '0);
    mrow = 0;
    mcol = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    // full ramp frame
    clr_stats();
    for (int i = 0; i < 784; i++) begin
      push(16'(i), 1'b1, 1'b0);
      if (i == 116) begin
        check("e0", {384'b0, el(0)}, 400'd0);
        check("e4", {384'b0, el(4)}, 400'd4);
        check("e20", {384'b0, el(20)}, 400'd112);
        check("e24", {384'b0, el(24)}, 400'd116);
        check("first_row", {395'b0, win_row}, 400'd0);
        check("first_col", {395'b0, win_col}, 400'd0);
      end
      if (i == 4*28+27) begin
        check("wrap_col", {395'b0, win_col}, 400'd23);
      end
      if (i >= 5*28 && i <= 5*28+3) begin
        check("wrap_nowin", {399'b0, window_valid}, '0);
      end
      if (i == 5*28+4) begin
        check("wrap_row1", {395'b0, win_row}, 400'd1);
        check("wrap_col0", {395'b0, win_col}, 400'd0);
      end
    end
    check("first_idx", 400'(first), 400'd116);
    check("win_count", 400'(win_cnt), 400'd576);
    check("fd_count", 400'(fd_cnt), 400'd1);
    push(16'h0, 1'b0, 1'b0);
    check("fd_single", {399'b0, frame_done}, '0);

    // random valid gaps over a full frame
    clr_stats();
    p = 0;
    while (p < 784) begin
      if ($urandom_range(0, 1) == 1) begin
        push(16'(p), 1'b1, 1'b0);
        p++;
      end else begin
        push(16'($urandom), 1'b0, 1'b0);
      end
    end
    check("gap_win_count", 400'(win_cnt), 400'd576);
    check("gap_fd_count", 400'(fd_cnt), 400'd1);

    // restart mid-frame, constant 0x0200 frame
    for (int i = 0; i < 300; i++) push(16'(i), 1'b1, 1'b0);
    clr_stats();
    push(16'h0200, 1'b1, 1'b1);
    for (int i = 1; i < 784; i++) begin
      push(16'h0200, 1'b1, 1'b0);
      if (i == 116) begin
        sum = '0;
        for (int k = 0; k < 25; k++) begin
          s = $signed(el(k)) * $signed(16'sh0100);
          sum = sum + 32'(s >>> 8);
        end
        check("conv_sum", {368'b0, sum}, 400'h3200);
      end
    end
    check("rs_first_idx", 400'(first), 400'd116);
    check("rs_win_count", 400'(win_cnt), 400'd576);
    check("rs_fd_count", 400'(fd_cnt), 400'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
